hilo_muldiv_unit: RTL and testbench

//  Multi-cycle multiply/divide engine with architectural HI/LO registers, downstream of the ALU.

---
 rtl/hilo_muldiv_unit.sv | 193 +++++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - iterative multiply/divide engine with HI/LO registers
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start, op, opa, opb    operation request (op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   hi_we, lo_we, wdata    MTHI/MTLO writes, honoured only while not busy
//   busy                   high from the cycle after start through the fix-up cycle
//   done, div_by_zero      one-cycle completion pulse and divide-by-zero indication
//   hi, lo                 architectural HI/LO registers
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] opa_raw_q, opa_raw_d;
    // Multiplicand for multiply, divisor for divide.
    logic [WIDTH-1:0] addend_q, addend_d;
    // {acc_hi, acc_lo}: product/multiplier shift pair, or remainder/quotient pair.
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic             sign_a, sign_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] rem_diff;
    logic [2*WIDTH-1:0] product;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        opa_raw_d = opa_raw_q;
        addend_d  = addend_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;
        sign_a    = 1'b0;
        sign_b    = 1'b0;
        mul_sum   = '0;
        rem_shift = '0;
        rem_diff  = '0;
        product   = '0;

        case (state_q)
            S_IDLE: begin
                // MT writes land at this edge even when a start is accepted;
                // the result written at FIX supersedes them.
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    // op[0]=0 selects the signed variants (MULT, DIV).
                    sign_a    = ~op[0] & opa[WIDTH-1];
                    sign_b    = ~op[0] & opb[WIDTH-1];
                    state_d   = S_CALC;
                    cnt_d     = '0;
                    op_d      = op;
                    opa_raw_d = opa;
                    neg_res_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    acc_hi_d  = '0;
                    acc_lo_d  = sign_a ? (~opa + 1'b1) : opa;
                    addend_d  = sign_b ? (~opb + 1'b1) : opb;
                end
            end

            S_CALC: begin
                if (!op_q[1]) begin
                    // Shift-add: the multiplier drains out of acc_lo's LSB while
                    // product bits shift in from the top.
                    mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, addend_q} : '0);
                    {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[WIDTH-1:1]};
                end else begin
                    // Restoring divide; the true difference always fits in WIDTH
                    // bits because the partial remainder stays below the divisor.
                    rem_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
                    rem_diff  = rem_shift[WIDTH-1:0] - addend_q;
                    if (rem_shift >= {1'b0, addend_q}) begin
                        acc_hi_d = rem_diff;
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi_d = rem_shift[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                    end
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIX;
                    cnt_d   = '0;
                end
            end

            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (!op_q[1]) begin
                    product = {acc_hi_q, acc_lo_q};
                    if (neg_res_q) product = ~product + 1'b1;
                    {hi_d, lo_d} = product;
                end else if (addend_q == '0) begin
                    // The iteration ran on a zero divisor; its result is discarded.
                    hi_d  = opa_raw_q;
                    lo_d  = '1;
                    dbz_d = 1'b1;
                end else begin
                    lo_d = neg_res_q ? (~acc_lo_q + 1'b1) : acc_lo_q;
                    hi_d = neg_rem_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
                end
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            opa_raw_q <= '0;
            addend_q  <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            opa_raw_q <= opa_raw_d;
            addend_q  <= addend_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - self-checking bench for hilo_muldiv_unit
module tb_hilo_muldiv_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    op = 2'd0;
    logic [W-1:0]  opa = '0;
    logic [W-1:0]  opb = '0;
    logic          hi_we = 1'b0;
    logic          lo_we = 1'b0;
    logic [W-1:0]  wdata = '0;
    logic          busy;
    logic          done;
    logic          div_by_zero;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    hilo_muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .opa         (opa),
        .opb         (opb),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Reference: {div_by_zero, hi, lo} from plain 64-bit arithmetic.
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, sq, sr;
        logic [63:0] p, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (o == 2'd0) begin
            p = 64'(sa * sb);
            return {1'b0, p};
        end
        if (o == 2'd1) begin
            p = {32'd0, a} * {32'd0, b};
            return {1'b0, p};
        end
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (o == 2'd2) begin
            sq = sa / sb;
            sr = sa % sb;
            uq = 64'(sq);
            ur = 64'(sr);
        end else begin
            uq = {32'd0, a} / {32'd0, b};
            ur = {32'd0, a} % {32'd0, b};
        end
        return {1'b0, ur[31:0], uq[31:0]};
    endfunction

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("idle_busy", 64'(busy), 64'd0);
            chk("idle_done", 64'(done), 64'd0);
            chk("idle_dbz", 64'(div_by_zero), 64'd0);
            chk("idle_hilo", {hi, lo}, {exp_hi, exp_lo});
        end
    endtask

    // Called at a negedge: that cycle is cycle 0. inj>0 pulses start(DIV)+hi_we
    // in that busy cycle, which must be ignored.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int inj);
        logic [64:0] e;
        e = model(o, a, b);
        start = 1'b1;
        op    = o;
        opa   = a;
        opb   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        op    = 2'($urandom);
        opa   = $urandom;
        opb   = $urandom;
        for (int k = 1; k <= W + 1; k++) begin
            @(negedge clk);
            chk("busy_run", 64'(busy), 64'd1);
            chk("done_early", 64'(done), 64'd0);
            chk("hilo_hold", {hi, lo}, {exp_hi, exp_lo});
            if (k == inj) begin
                start = 1'b1;
                op    = 2'd2;
                hi_we = 1'b1;
                wdata = 32'h0000_DEAD;
            end else begin
                start = 1'b0;
                hi_we = 1'b0;
            end
        end
        start = 1'b0;
        hi_we = 1'b0;
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'd1);
        chk("busy_done", 64'(busy), 64'd0);
        chk("dbz", 64'(div_by_zero), 64'(e[64]));
        chk("hi", 64'(hi), 64'(e[63:32]));
        chk("lo", 64'(lo), 64'(e[31:0]));
        exp_hi = e[63:32];
        exp_lo = e[31:0];
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        // Reset state
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dbz", 64'(div_by_zero), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Directed cases
        run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 0);
        idle(1);
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0);          // back-to-back from done cycle
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(2'd3, 32'd100, 32'd0, 0);
        idle(1);
        run_op(2'd2, 32'hFFFF_FF9C, 32'd0, 0);
        idle(1);

        // Start and MTHI while busy are ignored
        run_op(2'd1, 32'd5, 32'd6, 5);
        idle(2);
        hi_we = 1'b1;
        wdata = 32'h0000_1234;
        @(negedge clk);
        hi_we  = 1'b0;
        exp_hi = 32'h0000_1234;
        chk("mthi", 64'(hi), 64'h1234);
        idle(1);

        // MTLO in the start cycle lands first, then the result overwrites it
        lo_we  = 1'b1;
        wdata  = 32'hCAFE_F00D;
        exp_lo = 32'hCAFE_F00D;
        run_op(2'd3, 32'd1000, 32'd7, 0);
        idle(1);

        // Reset mid-operation
        start = 1'b1;
        op    = 2'd0;
        opa   = 32'd123;
        opb   = 32'd456;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k < 10; k++) begin
            @(negedge clk);
            chk("busy_pre_rst", 64'(busy), 64'd1);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_hi = '0;
        exp_lo = '0;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(W + 4);
        run_op(2'd3, 32'd9, 32'd4, 0);
        idle(1);

        // Randomized operations against the model
        for (int i = 0; i < 16; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            run_op(ro, ra, rb, 0);
            if (i % 3 == 0) idle(1);
        end
        idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
